// File: rtl/ram8_bist_if.sv
// RAM-side bus of the BIST controller: write data, write enable, address, read data.
interface ram8_bist_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
);
  logic [WIDTH-1:0]  ram_in_o;
  logic              ram_load_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [WIDTH-1:0]  ram_out_i;

  // BIST controller side: drives the RAM, receives read data.
  modport master (
    output ram_in_o,
    output ram_load_o,
    output ram_addr_o,
    input  ram_out_i
  );

  // RAM side: receives commands, returns read data combinationally.
  modport slave (
    input  ram_in_o,
    input  ram_load_o,
    input  ram_addr_o,
    output ram_out_i
  );
endinterface

// File: rtl/ram8_bist.sv
// March-style BIST for a small zero-latency RAM: write P(a)=seed+a, read/compare,
// then repeat with ~P(a). Reports pass, first failing address and a saturating error count.
module ram8_bist #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [WIDTH-1:0]  seed_i,
  ram8_bist_if.master       ram_bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [ADDR_W+1:0] err_count_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWr0,
    StRd0,
    StWr1,
    StRd1,
    StDone
  } state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W+1:0] ErrMax   = '1;

  state_e            r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [ADDR_W-1:0] r_fail_addr, w_fail_addr_next;
  logic [ADDR_W+1:0] r_err, w_err_next;
  logic [WIDTH-1:0]  r_seed, w_seed_next;
  logic [WIDTH-1:0]  w_pat, w_expect;
  logic              w_wr, w_rd, w_pass1, w_last, w_mismatch;

  assign w_wr       = (r_state == StWr0) || (r_state == StWr1);
  assign w_rd       = (r_state == StRd0) || (r_state == StRd1);
  assign w_pass1    = (r_state == StWr1) || (r_state == StRd1);
  assign w_last     = (r_addr == LastAddr);
  // Modulo-2^WIDTH sum; carry-out is intentionally dropped.
  assign w_pat      = r_seed + WIDTH'(r_addr);
  assign w_expect   = w_pass1 ? ~w_pat : w_pat;
  assign w_mismatch = w_rd && (ram_bus.ram_out_i != w_expect);

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_fail_addr <= '0;
      r_err       <= '0;
      r_seed      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_addr      <= w_addr_next;
      r_fail_addr <= w_fail_addr_next;
      r_err       <= w_err_next;
      r_seed      <= w_seed_next;
    end
  end

  // Next-state, address sequencing and compare bookkeeping.
  always_comb begin
    w_state_next     = r_state;
    w_addr_next      = r_addr;
    w_fail_addr_next = r_fail_addr;
    w_err_next       = r_err;
    w_seed_next      = r_seed;
    case (r_state)
      StIdle, StDone: begin
        if (start_i) begin
          w_seed_next      = seed_i;
          w_err_next       = '0;
          w_fail_addr_next = '0;
          w_addr_next      = '0;
          w_state_next     = StWr0;
        end
      end
      StWr0, StWr1: begin
        w_addr_next = w_last ? '0 : r_addr + ADDR_W'(1);
        if (w_last) w_state_next = (r_state == StWr0) ? StRd0 : StRd1;
      end
      StRd0, StRd1: begin
        w_addr_next = w_last ? '0 : r_addr + ADDR_W'(1);
        if (w_mismatch) begin
          if (r_err != ErrMax) w_err_next = r_err + 1'b1;
          if (r_err == '0) w_fail_addr_next = r_addr;
        end
        if (w_last) w_state_next = (r_state == StRd0) ? StWr1 : StDone;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decoded from state, counter and registers only.
  always_comb begin
    ram_bus.ram_load_o = w_wr;
    ram_bus.ram_addr_o = r_addr;
    ram_bus.ram_in_o   = w_wr ? w_expect : '0;
    busy_o             = w_wr || w_rd;
    done_o             = (r_state == StDone);
    pass_o             = (r_state == StDone) && (r_err == '0);
    fail_addr_o        = r_fail_addr;
    err_count_o        = r_err;
  end

endmodule

// File: tb/tb_ram8_bist.sv
// Directed bench for ram8_bist with a behavioural RAM8 and simple read-data fault injection.
module tb_ram8_bist;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;

  logic              clk_i   = 1'b0;
  logic              rst_ni  = 1'b0;
  logic              start_i = 1'b0;
  logic [WIDTH-1:0]  seed_i  = '0;
  logic              busy_o, done_o, pass_o;
  logic [ADDR_W-1:0] fail_addr_o;
  logic [ADDR_W+1:0] err_count_o;

  ram8_bist_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  ram8_bist #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .seed_i     (seed_i),
    .ram_bus    (bus),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .pass_o     (pass_o),
    .fail_addr_o(fail_addr_o),
    .err_count_o(err_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural RAM8 plus a log of every write the controller issues.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wr_log [$];
  logic [WIDTH-1:0] ram_rd;
  int               fault_mode = 0;  // 0 healthy, 1 bit0 stuck-1 at addr 5, 2 read tied 0

  initial for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;

  always @(posedge clk_i) begin
    if (bus.ram_load_o) begin
      mem[bus.ram_addr_o] <= bus.ram_in_o;
      wr_log.push_back(bus.ram_in_o);
    end
  end

  always_comb begin
    ram_rd = mem[bus.ram_addr_o];
    if (fault_mode == 1 && bus.ram_addr_o == 3'd5) ram_rd[0] = 1'b1;
    else if (fault_mode == 2) ram_rd = '0;
  end
  assign bus.ram_out_i = ram_rd;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept a start at edge 0, optionally pulse start at two busy cycles, end in cycle 33.
  task automatic run_bist(input logic [WIDTH-1:0] seed, input int pulse_a, input int pulse_b);
    @(negedge clk_i);
    seed_i  = seed;
    start_i = 1'b1;
    wr_log.delete();
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    check("accept_busy", 32'(busy_o), 32'd1);
    check("accept_done", 32'(done_o), 32'd0);
    for (int c = 1; c <= 32; c++) begin
      start_i = (c == pulse_a) || (c == pulse_b);
      if (c == 32) check("done_cycle32", 32'(done_o), 32'd0);
      @(posedge clk_i);
      #1;
    end
    start_i = 1'b0;
    check("done_cycle33", 32'(done_o), 32'd1);
    check("busy_cycle33", 32'(busy_o), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic pass, input logic [31:0] errs,
                              input logic [31:0] faddr);
    check({tag, "_pass"}, 32'(pass_o), 32'(pass));
    check({tag, "_errs"}, 32'(err_count_o), errs);
    check({tag, "_faddr"}, 32'(fail_addr_o), faddr);
  endtask

  logic [WIDTH-1:0] exp_wr [16] = '{
    16'h1234, 16'h1235, 16'h1236, 16'h1237, 16'h1238, 16'h1239, 16'h123A, 16'h123B,
    16'hEDCB, 16'hEDCA, 16'hEDC9, 16'hEDC8, 16'hEDC7, 16'hEDC6, 16'hEDC5, 16'hEDC4
  };

  initial begin
    // Reset state
    #12;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_pass", 32'(pass_o), 32'd0);
    check("rst_load", 32'(bus.ram_load_o), 32'd0);
    check("rst_din", 32'(bus.ram_in_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Healthy RAM, seed 0x1234, write order check
    run_bist(16'h1234, 0, 0);
    check_result("healthy", 1'b1, 32'd0, 32'd0);
    check("wr_count", 32'(wr_log.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < wr_log.size()) check($sformatf("wr%0d", i), 32'(wr_log[i]), 32'(exp_wr[i]));

    // Seed wrap, restarted directly from DONE
    run_bist(16'hFFFE, 0, 0);
    check_result("wrap", 1'b1, 32'd0, 32'd0);
    if (wr_log.size() == 16) begin
      check("wrap_p2", 32'(wr_log[2]), 32'h0000);
      check("wrap_p7", 32'(wr_log[7]), 32'h0005);
      check("wrap_np2", 32'(wr_log[10]), 32'hFFFF);
    end

    // bit0 stuck at 1 on address 5: only the complement pass sees it
    fault_mode = 1;
    run_bist(16'h1234, 0, 0);
    check_result("stuck1", 1'b0, 32'd1, 32'd5);

    // Read data tied to zero, seed 0
    fault_mode = 2;
    run_bist(16'h0000, 0, 0);
    check_result("tied0", 1'b0, 32'd15, 32'd1);

    // Start pulses while busy are ignored
    fault_mode = 0;
    run_bist(16'h1234, 5, 20);
    check_result("ignore_start", 1'b1, 32'd0, 32'd0);

    // Mid-RD0 asynchronous reset with errors already accumulated
    fault_mode = 2;
    @(negedge clk_i);
    seed_i  = 16'h0000;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (11) begin
      @(posedge clk_i);
      #1;
    end
    check("pre_rst_errs", 32'(err_count_o), 32'd2);
    check("pre_rst_faddr", 32'(fail_addr_o), 32'd1);
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_errs", 32'(err_count_o), 32'd0);
    check("arst_faddr", 32'(fail_addr_o), 32'd0);
    check("arst_addr", 32'(bus.ram_addr_o), 32'd0);
    check("arst_done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    rst_ni     = 1'b1;
    fault_mode = 0;
    run_bist(16'h1234, 0, 0);
    check_result("post_rst", 1'b1, 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram8_bist.md
# ram8_bist

Built-in self-test controller that sits on the initiator side of an 8-word, 16-bit RAM (clk_i/in_i/load_i/address_i/out_o style).
- On a start pulse it writes an address-dependent pattern to every word, reads it back and compares.
- It then repeats the write/read/compare with the bitwise complement of the pattern.
- It reports pass/fail, the first failing address and a saturating mismatch count.
- It replaces hand-written stimulus sequences for power-up and regression checks of the register-file memories.

## Interface
Parameters:
- WIDTH, 16, data word width
- DEPTH, 8, number of words, power of two
- ADDR_W, 3, address width, equal to log2(DEPTH)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- start_i  in  1  start request, sampled on rising edge
- seed_i  in  WIDTH  pattern seed, captured when start is accepted
- ram_out_i  in  WIDTH  RAM read data; combinational from ram_addr_o (zero read latency)
- ram_in_o  out  WIDTH  RAM write data
- ram_load_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_W  RAM address
- busy_o  out  1  test in progress
- done_o  out  1  test finished; sticky until next accepted start or reset
- pass_o  out  1  valid when done_o=1; 1 means zero mismatches
- fail_addr_o  out  ADDR_W  address of first mismatch; 0 if none
- err_count_o  out  ADDR_W+2  mismatch count, saturating at all-ones

## Operation
- States: IDLE, WR0, RD0, WR1, RD1, DONE. A registered address counter `a` runs 0..DEPTH-1 in each of WR0, RD0, WR1 and RD1.
- Pattern: P(a) = seed + a, 16-bit modulo sum (wraps, no carry-out). Pass 0 uses P(a); pass 1 uses ~P(a).
- IDLE or DONE with start_i=1:
  - capture seed_i into a register;
  - clear err_count, fail_addr, pass and done;
  - a <= 0; go to WR0.
- WRx:
  - drive ram_load_o=1, ram_addr_o=a, ram_in_o = pattern of this pass;
  - a increments each cycle;
  - when a = DEPTH-1, set a <= 0 and go to RDx.
- RDx:
  - drive ram_load_o=0, ram_addr_o=a;
  - compare ram_out_i against the expected pattern on the same edge;
  - on mismatch: increment err_count (saturating); if it was 0 before, latch fail_addr <= a;
  - at a = DEPTH-1, RD0 goes to WR1 and RD1 goes to DONE.
- DONE:
  - done_o=1, busy_o=0;
  - pass_o = (err_count == 0), evaluated including the final compare.
- start_i while busy_o=1 is ignored. There is no abort except reset.
- Outputs are registered, or decoded from state and the counter only. ram_load_o is 0 in IDLE and DONE.
- Reset (any time, including mid-pass):
  - state IDLE, a=0;
  - ram_load_o=0, ram_addr_o=0, ram_in_o=0;
  - busy_o=0, done_o=0, pass_o=0, fail_addr_o=0, err_count_o=0.
  - RAM contents are not restored.

## Timing
- Cycle numbering: start accepted at edge 0.
- WR0 occupies cycles 1..DEPTH; RD0 DEPTH+1..2·DEPTH; WR1 2·DEPTH+1..3·DEPTH; RD1 3·DEPTH+1..4·DEPTH.
- done_o=1 from cycle 4·DEPTH+1 (cycle 33 at defaults). Total latency is 4·DEPTH+1 cycles.
- busy_o is high exactly during WR0..RD1.
- A write at address a is visible on ram_out_i from the next cycle. The first RD0 read occurs one cycle after the last WR0 write, so no bypass is needed.
- A start in DONE restarts immediately: done_o falls on the acceptance edge, and busy_o rises the following cycle.
- Back-to-back start held high: the controller re-runs continuously and done_o is high for exactly one cycle between runs.

## Test plan
- Healthy RAM8, seed=0x1234, start pulse:
  - writes in order 0x1234..0x123B, then 0xEDCB..0xEDC4;
  - done at cycle 33 with pass_o=1, err_count_o=0, fail_addr_o=0.
- Seed wrap, seed=0xFFFE:
  - P(2) = 0x0000 and P(7) = 0x0005;
  - pass_o=1.
- Fault injection, ram_out_i bit0 forced to 1 at address 5, seed=0x1234:
  - RD0 passes (0x1239);
  - RD1 mismatch (expected 0xEDC6);
  - err_count_o=1, fail_addr_o=5, pass_o=0.
- Fault injection, ram_out_i tied to 0x0000, seed=0x0000:
  - RD0 fails at addresses 1..7 (7 errors);
  - RD1 fails at all 8 (15 total);
  - fail_addr_o=1, err_count_o=15, pass_o=0.
- Reset asserted at cycle 12 (mid-RD0):
  - all outputs are 0 immediately, asynchronously;
  - a new start after release gives a full 33-cycle run with pass_o=1.
- start_i pulsed at cycles 5 and 20:
  - both ignored;
  - done still at cycle 33.
